// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with least-recently-granted rotation.
// Grants are combinational from the requests and a registered pointer. The
// pointer only moves when the consumer accepts a winner (update_lru_i), so a
// stalled consumer can hold its transaction without disturbing fairness.
// An optional checker flags illegal grant vectors with a sticky error bit.
module rr_arbiter4 #(
    parameter bit CHECK_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       req2_i,
    input  logic       req3_i,
    input  logic       update_lru_i,
    output logic       grant0_o,
    output logic       grant1_o,
    output logic       grant2_o,
    output logic       grant3_o,
    output logic       grant_valid_o,
    output logic [1:0] grant_index_o,
    output logic       error_o
);

    logic [3:0] req;
    logic [1:0] last_grant;
    logic [3:0] grant_sel;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       found;

    assign req = {req3_i, req2_i, req1_i, req0_i};

    // Walk requesters from last_grant+1 around to last_grant; first requester wins.
    always_comb begin
        grant_sel = 4'b0000;
        found     = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                grant_sel[idx] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    // Single net carrying the grant vector; every output and the checker read it.
    assign grant = grant_sel;

    assign grant0_o      = grant[0];
    assign grant1_o      = grant[1];
    assign grant2_o      = grant[2];
    assign grant3_o      = grant[3];
    assign grant_valid_o = |grant;

    // Encode the one-hot grant to a binary index (0 when nothing is granted).
    always_comb begin
        grant_index_o = 2'd0;
        if (grant[3])      grant_index_o = 2'd3;
        else if (grant[2]) grant_index_o = 2'd2;
        else if (grant[1]) grant_index_o = 2'd1;
    end

    // Priority pointer: reset puts requester 3 last so requester 0 leads.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 2'd3;
        end else if (update_lru_i && grant_valid_o) begin
            last_grant <= grant_index_o;
        end
    end

    generate
        if (CHECK_ENABLE) begin : g_check
            logic multi;
            logic stray;
            logic missed;
            logic fault;
            logic err;

            assign multi  = (grant & (grant - 4'd1)) != 4'd0;
            assign stray  = (grant & ~req) != 4'd0;
            assign missed = (req != 4'd0) && (grant == 4'd0);
            assign fault  = multi | stray | missed;

            // Sticky error flag, cleared only by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    err <= 1'b0;
                end else if (fault) begin
                    err <= 1'b1;
                end
            end

`ifndef SYNTHESIS
            // Simulation-only report of each faulty cycle.
            always @(posedge clk) begin
                if (!reset && fault) begin
                    $display("arbiter4 grant error at time %0t", $time);
                end
            end
`endif

            assign error_o = err;
        end else begin : g_nocheck
            assign error_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: rotation, pointer freeze, reset, single
// requester, a random run against a reference model, and checker injection.
module tb_rr_arbiter4;

    logic       clk;
    logic       reset;
    logic       req0, req1, req2, req3;
    logic       update_lru;
    logic       grant0, grant1, grant2, grant3;
    logic       grant_valid;
    logic [1:0] grant_index;
    logic       error;

    int checks   = 0;
    int failures = 0;

    rr_arbiter4 #(.CHECK_ENABLE(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_i        (req0),
        .req1_i        (req1),
        .req2_i        (req2),
        .req3_i        (req3),
        .update_lru_i  (update_lru),
        .grant0_o      (grant0),
        .grant1_o      (grant1),
        .grant2_o      (grant2),
        .grant3_o      (grant3),
        .grant_valid_o (grant_valid),
        .grant_index_o (grant_index),
        .error_o       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge and let combinational logic settle.
    task automatic drive(input logic rst, input logic [3:0] r, input logic upd);
        @(negedge clk);
        reset      = rst;
        {req3, req2, req1, req0} = r;
        update_lru = upd;
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] exp_vec);
        logic [1:0] exp_idx;
        exp_idx = 2'd0;
        if (exp_vec[1]) exp_idx = 2'd1;
        if (exp_vec[2]) exp_idx = 2'd2;
        if (exp_vec[3]) exp_idx = 2'd3;
        check({tag, "_vec"}, {28'd0, grant3, grant2, grant1, grant0}, {28'd0, exp_vec});
        check({tag, "_idx"}, {30'd0, grant_index}, {30'd0, exp_idx});
        check({tag, "_vld"}, {31'd0, grant_valid}, {31'd0, |exp_vec});
    endtask

    initial begin
        int         mdl_last;
        logic [3:0] r;
        logic       u;
        int         best;
        int         bestd;
        int         d;
        logic [3:0] exp_vec;

        reset = 1'b1;
        {req3, req2, req1, req0} = 4'b0000;
        update_lru = 1'b0;

        // Reset state
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        check("reset_err", {31'd0, error}, 32'd0);
        check_grant("reset_idle", 4'b0000);

        // Full rotation with all four requesting
        drive(1'b0, 4'b1111, 1'b1); check_grant("rot0", 4'b0001);
        drive(1'b0, 4'b1111, 1'b1); check_grant("rot1", 4'b0010);
        drive(1'b0, 4'b1111, 1'b1); check_grant("rot2", 4'b0100);
        drive(1'b0, 4'b1111, 1'b1); check_grant("rot3", 4'b1000);
        drive(1'b0, 4'b1111, 1'b1); check_grant("rot4", 4'b0001);
        check("rot_err", {31'd0, error}, 32'd0);

        // Alternating pair 1 and 3 from reset
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b1010, 1'b1); check_grant("pair0", 4'b0010);
        drive(1'b0, 4'b1010, 1'b1); check_grant("pair1", 4'b1000);
        drive(1'b0, 4'b1010, 1'b1); check_grant("pair2", 4'b0010);
        drive(1'b0, 4'b1010, 1'b1); check_grant("pair3", 4'b1000);
        drive(1'b0, 4'b0000, 1'b1); check_grant("none0", 4'b0000);
        drive(1'b0, 4'b0000, 1'b1); check_grant("none1", 4'b0000);
        // Pointer still 3, so requester 0 leads
        drive(1'b0, 4'b1111, 0);    check_grant("ptr_hold", 4'b0001);

        // Advance to granting 2, then freeze with update low
        drive(1'b0, 4'b1111, 1'b1); check_grant("adv0", 4'b0001);
        drive(1'b0, 4'b1111, 1'b1); check_grant("adv1", 4'b0010);
        drive(1'b0, 4'b1111, 1'b1); check_grant("adv2", 4'b0100);
        drive(1'b0, 4'b1111, 1'b0); check_grant("frz0", 4'b1000);
        drive(1'b0, 4'b1111, 1'b0); check_grant("frz1", 4'b1000);
        drive(1'b0, 4'b1111, 1'b0); check_grant("frz2", 4'b1000);
        drive(1'b0, 4'b1111, 1'b1); check_grant("frz_commit", 4'b1000);
        drive(1'b0, 4'b1111, 1'b1); check_grant("after_frz", 4'b0001);

        // Reset mid-rotation with last_grant=1
        drive(1'b0, 4'b1111, 1'b1); check_grant("mid_pre", 4'b0010);
        drive(1'b1, 4'b1111, 1'b1);
        drive(1'b0, 4'b1111, 1'b1); check_grant("mid_reset", 4'b0001);

        // Single persistent requester
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0100, 1'b1);
            check_grant("single2", 4'b0100);
        end

        // Random run against a distance-based reference model
        drive(1'b1, 4'b0000, 1'b0);
        mdl_last = 3;
        for (int n = 0; n < 1000; n++) begin
            r = 4'($urandom_range(0, 15));
            u = 1'($urandom_range(0, 1));
            drive(1'b0, r, u);
            best  = -1;
            bestd = 5;
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    d = (i - mdl_last - 1 + 8) % 4;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
            exp_vec = 4'b0000;
            if (best >= 0) exp_vec[best] = 1'b1;
            check("rand_vec", {28'd0, grant3, grant2, grant1, grant0}, {28'd0, exp_vec});
            check("rand_err", {31'd0, error}, 32'd0);
            if (u && best >= 0) mdl_last = best;
        end

        // Checker: inject a two-hot grant vector for one cycle
        drive(1'b0, 4'b1111, 1'b0);
        check("inj_pre_err", {31'd0, error}, 32'd0);
        force dut.grant = 4'b0011;
        @(negedge clk);
        release dut.grant;
        #1;
        check("inj_err0", {31'd0, error}, 32'd1);
        drive(1'b0, 4'b1111, 1'b0); check("inj_err1", {31'd0, error}, 32'd1);
        drive(1'b0, 4'b0000, 1'b0); check("inj_err2", {31'd0, error}, 32'd1);
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0); check("inj_clear", {31'd0, error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with least-recently-granted priority rotation.
- Grants are combinational from the current requests and a registered priority pointer.
- The pointer advances only when the consumer signals it may take a new winner (update_lru_i).
- Used by the store buffer to pick which strand's pending store issues to the L2 cache next.
- Includes a built-in grant-consistency checker (sticky error flag plus simulation message).

Parameters:
- CHECK_ENABLE, 1, when 1 the grant-consistency checker is active; when 0 error_o is tied 0 and no messages are printed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- req0_i  input  1  request from requester 0
- req1_i  input  1  request from requester 1
- req2_i  input  1  request from requester 2
- req3_i  input  1  request from requester 3
- update_lru_i  input  1  commit this cycle's grant to the priority state
- grant0_o  output  1  grant to requester 0 (combinational)
- grant1_o  output  1  grant to requester 1 (combinational)
- grant2_o  output  1  grant to requester 2 (combinational)
- grant3_o  output  1  grant to requester 3 (combinational)
- grant_valid_o  output  1  OR of all grants
- grant_index_o  output  2  binary index of the granted requester; 0 when grant_valid_o=0
- error_o  output  1  sticky: checker detected an illegal grant vector

Behaviour:
- State: 2-bit last_grant register; 1-bit error register.
- Reset (sync, active-high):
  - last_grant <= 3, so requester 0 has top priority after reset.
  - error_o <= 0.
  - Grant outputs stay combinational; after reset they follow the order 0,1,2,3.
- Priority order: (last_grant+1) mod 4, +2, +3, then last_grant itself (lowest). Wrap-around is mod 4.
- Grant selection:
  - Exactly one grant is asserted: the first requesting index in priority order.
  - All grants are 0 when no request is asserted.
  - Zero-cycle latency from req to grant.
- Pointer update on posedge clk, when not in reset:
  - If update_lru_i=1 and any grant is asserted, last_grant <= the granted index.
  - Otherwise last_grant holds.
- With update_lru_i=0, grants may still change combinationally as requests change; the pointer is frozen. This lets the consumer hold a transaction without disturbing fairness.
- A single persistent requester is granted every cycle.
- Multiple persistent requesters with update_lru_i=1 each cycle rotate strictly round-robin.
- A requester that drops its request loses its slot; no grant memory is kept.
- Reset asserted mid-operation: pointer returns to 3 at that edge regardless of update_lru_i or requests.
- Checker (evaluated each posedge when CHECK_ENABLE=1 and reset=0):
  - Fault conditions: more than one grant asserted; or a grant asserted whose request is 0; or any request asserted with no grant.
  - On a fault: error_o <= 1 (sticky until reset) and a simulation-only message "arbiter4 grant error" with the time is printed.
  - The message printing is excluded from synthesis.
- grant_index_o and grant_valid_o are derived combinationally from the grant vector.

Test Plan:
- Reset, then req=0b1111 with update_lru_i=1 for 5 cycles -> grant index sequence 0,1,2,3,0; error_o=0.
- After reset, req=0b1010 with update_lru_i=1 -> grants 1,3,1,3; with req=0b0000 -> all grants 0, grant_valid_o=0, pointer unchanged.
- After granting 2, hold update_lru_i=0 for 3 cycles with req=0b1111 -> grant stays on 3 each cycle. Raise update_lru_i for one cycle -> next cycle grant is 0.
- Mid-rotation (last_grant=1), assert reset for one cycle with req=0b1111 and update_lru_i=1 -> next cycle grant 0.
- Only req2_i=1 for 4 cycles with update_lru_i=1 -> grant2_o=1 every cycle, grant_index_o=2.
- Run random req/update_lru_i for 1000 cycles -> grants always one-hot-or-zero, granted req always 1, error_o stays 0. Separately, with CHECK_ENABLE=1, force the grant output through the bench to 0b0011 for one cycle -> error_o=1 from the next edge until reset.
